// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_byte_rx #(
   parameter int CLK_FREQ  = 10_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_wire_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   input  logic       ready_in,
   output logic       framing_err_out,
   output logic       overrun_out
);

   localparam int CPB   = CLK_FREQ / BAUD_RATE;
   localparam int HALF  = CPB / 2;
   localparam int CNT_W = $clog2(CPB);

   generate
      if (CPB < 4) begin : g_bad_cpb
         $error("uart_byte_rx: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             rx_meta_q, rx_s_q;
   logic             good_q;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q;
   logic             ovr_q, ovr_d;

   logic             sample_tick;
   logic             stop_good;
   logic             stop_bad;

   // State register, synchronizer and delivery registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         good_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rx_meta_q <= rx_wire_in;
         rx_s_q    <= rx_meta_q;
         good_q    <= stop_good;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= stop_bad;
         ovr_q     <= ovr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (sample_tick) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (sample_tick) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (sample_tick) begin
               cnt_d   = '0;
               state_d = rx_s_q ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output / strobe logic
   always_comb begin
      sample_tick = 1'b0;
      if (state_q == START)
         sample_tick = (cnt_q == CNT_W'(HALF - 1));
      else if (state_q == DATA || state_q == STOP)
         sample_tick = (cnt_q == CNT_W'(CPB - 1));
      stop_good = (state_q == STOP) && sample_tick && rx_s_q;
      stop_bad  = (state_q == STOP) && sample_tick && !rx_s_q;
   end

   // A finished byte lands one cycle after its stop sample; a full, unconsumed holding register wins.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (good_q) begin
         if (!valid_q || ready_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
   end

   assign data_out        = data_q;
   assign valid_out       = valid_q;
   assign framing_err_out = ferr_q;
   assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: stimulus pushes expected events, a negedge
// monitor pops and compares them as the receiver produces bytes and flags.
module tb_uart_byte_rx;

   localparam int CLK_FREQ  = 10_000_000;
   localparam int BAUD_RATE = 115_200;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;
   localparam int HALF      = CPB / 2;
   // 2 synchronizer edges + 1 IDLE edge, HALF + 9*CPB to the stop sample, 1 to delivery
   localparam int LAT       = 3 + HALF + 9 * CPB + 1;

   logic       clk_in     = 1'b0;
   logic       rst_in     = 1'b0;
   logic       rx_wire_in = 1'b1;
   logic       ready_in   = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       framing_err_out;
   logic       overrun_out;

   uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rx_wire_in      (rx_wire_in),
      .data_out        (data_out),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .framing_err_out (framing_err_out),
      .overrun_out     (overrun_out)
   );

   always #50 clk_in = ~clk_in;

   typedef enum int {EV_BYTE, EV_FRAME, EV_OVR} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   bit         held_v      = 1'b0;
   logic [7:0] held_d      = 8'h00;
   bit         prev_hold   = 1'b0;
   logic [7:0] prev_data   = 8'h00;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push(input ev_kind_t k, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic sb_pop(input ev_kind_t k, input logic [7:0] d);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d data %02h, expected nothing", k, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || (k == EV_BYTE && e.data !== d)) begin
            miscompares++;
            $display("FAIL event: got kind %0d data %02h, expected kind %0d data %02h",
                     k, d, e.kind, e.data);
         end else begin
            $display("ok   event kind %0d data %02h", k, d);
         end
      end
   endtask

   // Monitor: everything the DUT emits is matched against the expected-event queue.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            vectors++;
            if (!valid_out || data_out !== prev_data) begin
               miscompares++;
               $display("FAIL hold_stable: got valid %0b data %02h, expected valid 1 data %02h",
                        valid_out, data_out, prev_data);
            end
         end
         prev_hold = valid_out && !ready_in;
         prev_data = data_out;
         if (valid_out && ready_in) sb_pop(EV_BYTE, data_out);
         if (framing_err_out)       sb_pop(EV_FRAME, 8'h00);
         if (overrun_out)           sb_pop(EV_OVR, 8'h00);
      end
   end

   // Reference model: a good byte goes straight to the consumer if it is ready,
   // into the empty holding slot otherwise, and is lost as an overrun if the slot is full.
   task automatic model_frame(input logic [7:0] d, input bit good);
      if (!good)           push(EV_FRAME, 8'h00);
      else if (ready_in)   push(EV_BYTE, d);
      else if (held_v)     push(EV_OVR, 8'h00);
      else begin
         held_v = 1'b1;
         held_d = d;
      end
   endtask

   task automatic set_ready(input bit v);
      if (v && held_v) begin
         push(EV_BYTE, held_d);
         held_v = 1'b0;
      end
      ready_in = v;
   endtask

   task automatic accept_pulse();
      set_ready(1'b1);
      tick();
      ready_in = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit good, input int gap);
      model_frame(d, good);
      rx_wire_in = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx_wire_in = d[i];
         repeat (CPB) tick();
      end
      rx_wire_in = good;
      repeat (CPB) tick();
      repeat (gap) tick();
      if (!good) begin
         rx_wire_in = 1'b1;
         repeat (4) tick();
      end
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      bit good;
      int gap;
      logic [7:0] d;

      repeat (3) tick();
      check("rst_data", data_out, 8'h00);
      check("rst_valid", valid_out, 1'b0);
      check("rst_ferr", framing_err_out, 1'b0);
      check("rst_ovr", overrun_out, 1'b0);
      rst_in = 1'b1;
      repeat (10) tick();

      // Single byte held with ready low, then consumed
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1, 20);
         begin
            for (int i = 1; i <= 2000; i++) begin
               tick();
               if (valid_out) begin
                  lat = i;
                  break;
               end
            end
         end
      join
      check("a5_latency", lat, LAT);
      check("a5_valid", valid_out, 1'b1);
      check("a5_data", data_out, 8'hA5);
      accept_pulse();
      check("a5_valid_drop", valid_out, 1'b0);

      // Short low glitch
      rx_wire_in = 1'b0;
      repeat (20) tick();
      rx_wire_in = 1'b1;
      repeat (100) tick();
      check("glitch_no_valid", valid_out, 1'b0);

      // Framing error with a long break, then a clean byte
      send_frame(8'h5A, 1'b0, 200);
      send_frame(8'h3C, 1'b1, 20);
      check("3c_valid", valid_out, 1'b1);
      check("3c_data", data_out, 8'h3C);
      accept_pulse();

      // Overrun: second back-to-back byte dropped
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 20);
      check("overrun_keep", data_out, 8'h11);

      // Streaming with ready tied high, no idle gap
      set_ready(1'b1);
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h80, 1'b1, 20);
      set_ready(1'b0);

      // Reset mid-frame discards both the held byte and the partial one
      send_frame(8'h99, 1'b1, 10);
      rx_wire_in = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         rx_wire_in = d[i] & 1'b0 | ((8'hC3 >> i) & 8'h01) != 0;
         repeat (CPB) tick();
      end
      rx_wire_in = 1'b0;
      repeat (40) tick();
      rst_in     = 1'b0;
      rx_wire_in = 1'b1;
      held_v     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("mid_rst_data", data_out, 8'h00);
         check("mid_rst_valid", valid_out, 1'b0);
         check("mid_rst_ferr", framing_err_out, 1'b0);
         check("mid_rst_ovr", overrun_out, 1'b0);
         tick();
      end
      rst_in = 1'b1;
      repeat (50) tick();
      check("post_rst_valid", valid_out, 1'b0);
      send_frame(8'h7E, 1'b1, 20);
      check("7e_valid", valid_out, 1'b1);
      check("7e_data", data_out, 8'h7E);
      accept_pulse();

      // Randomized frames
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 3) == 0) accept_pulse();
         set_ready($urandom_range(0, 1) == 1);
         good = ($urandom_range(0, 4) != 0);
         gap  = good ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 150));
         d    = 8'($urandom_range(0, 255));
         send_frame(d, good, gap);
      end

      set_ready(1'b1);
      repeat (20) tick();
      set_ready(1'b0);
      repeat (5) tick();
      check("sb_drain", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
